// File: rtl/muldiv_unit.sv
// muldiv_unit: RV M-extension execution unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
// Radix-2 iterative shift-add multiply and restoring divide on operand magnitudes,
// with sign fix-up on the final iteration. One op in flight, valid/ready on both sides.
// Optional define MULDIV_FAST_MUL_EN: multiplies complete at the accept edge using a
// single-cycle product; divides are unaffected.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  op1,
    input  logic [XLEN-1:0]  op2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] out_tag
);
    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [2:0]        op;
    logic              neg_q;   // sign of product / quotient
    logic              neg_r;   // sign of remainder (follows op1)
    logic [XLEN-1:0]   bmag;    // |op2|: multiplicand or divisor
    logic [2*XLEN-1:0] acc;     // mul: {partial sum, multiplier}; div: {remainder, dividend/quotient}

    logic              s1, s2;
    logic [XLEN-1:0]   amag_in, bmag_in;
    logic              special;
    logic [XLEN-1:0]   special_res;

    logic [XLEN:0]     trial;
    logic [XLEN:0]     msum;
    logic [2*XLEN-1:0] step;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem;
    logic [XLEN-1:0]   final_res;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;
    logic [XLEN-1:0]   fast_res;
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Request decode: operand signedness, magnitudes and single-cycle divide special cases
    always_comb begin
        s1 = op1[XLEN-1] & (funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd6});
        s2 = op2[XLEN-1] & (funct3 inside {3'd0, 3'd1, 3'd4, 3'd6});
        amag_in = s1 ? -op1 : op1;
        bmag_in = s2 ? -op2 : op2;
        special     = 1'b0;
        special_res = '0;
        if (funct3[2]) begin
            if (op2 == '0) begin
                special     = 1'b1;
                special_res = funct3[1] ? op1 : '1;
            end else if (!funct3[0] && op1 == {1'b1, {(XLEN-1){1'b0}}} && op2 == '1) begin
                special     = 1'b1;
                special_res = funct3[1] ? '0 : op1;
            end
        end
`ifdef MULDIV_FAST_MUL_EN
        fast_a    = {{XLEN{s1}}, op1};
        fast_b    = {{XLEN{s2}}, op2};
        fast_prod = fast_a * fast_b;
        fast_res  = (funct3 == 3'd0) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`endif
    end

    // One radix-2 iteration, plus sign fix-up and result selection for the last one
    always_comb begin
        trial = acc[2*XLEN-1:XLEN-1] - {1'b0, bmag};
        msum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, bmag} : '0);
        if (op[2]) begin
            step = trial[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                               : {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end else begin
            step = {msum, acc[XLEN-1:1]};
        end
        prod = neg_q ? -step : step;
        quo  = neg_q ? -step[XLEN-1:0] : step[XLEN-1:0];
        rem  = neg_r ? -step[2*XLEN-1:XLEN] : step[2*XLEN-1:XLEN];
        case (op)
            3'd0:                final_res = prod[XLEN-1:0];
            3'd1, 3'd2, 3'd3:    final_res = prod[2*XLEN-1:XLEN];
            3'd4, 3'd5:          final_res = quo;
            default:             final_res = rem;
        endcase
    end

    // Control FSM and datapath registers; flush outranks every other transition
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            op      <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            bmag    <= '0;
            acc     <= '0;
            result  <= '0;
            out_tag <= '0;
        end else if (flush) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op      <= funct3;
                        out_tag <= in_tag;
                        neg_q   <= s1 ^ s2;
                        neg_r   <= s1;
                        bmag    <= bmag_in;
                        acc     <= {{XLEN{1'b0}}, amag_in};
                        cnt     <= CW'(XLEN);
                        if (special) begin
                            result <= special_res;
                            state  <= DONE;
                        end
`ifdef MULDIV_FAST_MUL_EN
                        else if (!funct3[2]) begin
                            result <= fast_res;
                            state  <= DONE;
                        end
`endif
                        else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    acc <= step;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        result <= final_res;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit (XLEN = 32).
// Directed vectors, backpressure, flush, asynchronous reset and randomized ops
// checked against a plain-arithmetic reference model.
module tb_muldiv_unit;
    localparam int XLEN     = 32;
    localparam int TAG_W    = 5;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT  = 0;
`else
    localparam int MUL_LAT  = XLEN;
`endif
    localparam int DIV_LAT  = XLEN;
    localparam int MAX_WAIT = 200;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       funct3;
    logic [XLEN-1:0]  op1;
    logic [XLEN-1:0]  op2;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  result;
    logic [TAG_W-1:0] out_tag;

    int tests_run    = 0;
    int tests_failed = 0;

    muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .funct3    (funct3),
        .op1       (op1),
        .op2       (op2),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    // Reference: RISC-V M semantics via 64-bit arithmetic
    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (f)
            3'd0: begin p = 64'(sa * sb); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(sa / sb);
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return 32'(ua / ub);
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb);
            end
            default: begin
                if (b == 32'd0) return a;
                return 32'(ua % ub);
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a,
                                       input logic [31:0] b);
        if (!f[2]) return MUL_LAT;
        if (b == 32'd0) return 0;
        if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        return DIV_LAT;
    endfunction

    // Present one request, wait (bounded) for out_valid; lat = edges after the accept edge
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] t, output logic [31:0] res, output logic [4:0] tg,
                          output int lat);
        funct3   = f;
        op1      = a;
        op2      = b;
        in_tag   = t;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < MAX_WAIT) begin
            @(posedge clk); #1;
            lat++;
        end
        tests_run++;
        if (out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout: out_valid=%b after %0d cycles, required 1 (funct3=%0d)",
                     out_valid, MAX_WAIT, f);
        end
        res = result;
        tg  = out_tag;
    endtask

    task automatic release_result;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0 || out_tag !== '0) begin
            tests_failed++;
            $display("FAIL reset_values: in_ready=%b out_valid=%b result=%h out_tag=%h, required 1 0 0 0",
                     in_ready, out_valid, result, out_tag);
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_table(input string name, input int n, input logic [2:0] fv [8],
                              input logic [31:0] av [8], input logic [31:0] bv [8],
                              input logic [31:0] ev [8], input int lv [8]);
        logic [31:0] res;
        logic [4:0]  tg;
        int          lat;
        for (int i = 0; i < n; i++) begin
            run_op(fv[i], av[i], bv[i], 5'(i + 3), res, tg, lat);
            tests_run++;
            if (res !== ev[i]) begin
                tests_failed++;
                $display("FAIL %s_result[%0d]: got %h, required %h", name, i, res, ev[i]);
            end
            tests_run++;
            if (tg !== 5'(i + 3)) begin
                tests_failed++;
                $display("FAIL %s_tag[%0d]: got %0d, required %0d", name, i, tg, i + 3);
            end
            tests_run++;
            if (lat !== lv[i]) begin
                tests_failed++;
                $display("FAIL %s_latency[%0d]: got %0d, required %0d", name, i, lat, lv[i]);
            end
            release_result();
            tests_run++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL %s_release[%0d]: in_ready=%b out_valid=%b, required 1 0",
                         name, i, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_mul;
        logic [2:0]  fv [8];
        logic [31:0] av [8], bv [8], ev [8];
        int          lv [8];
        fv = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0};
        av = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0};
        bv = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0};
        ev = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 0, 0, 0, 0};
        lv = '{MUL_LAT, MUL_LAT, MUL_LAT, MUL_LAT, 0, 0, 0, 0};
        test_table("mul", 4, fv, av, bv, ev, lv);
    endtask

    task automatic test_div;
        logic [2:0]  fv [8];
        logic [31:0] av [8], bv [8], ev [8];
        int          lv [8];
        fv = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd7, 3'd4, 3'd6};
        av = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5,
               32'h8000_0000, 32'h8000_0000};
        bv = '{32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        ev = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5,
               32'h8000_0000, 32'd0};
        lv = '{DIV_LAT, DIV_LAT, DIV_LAT, DIV_LAT, 0, 0, 0, 0};
        test_table("div", 8, fv, av, bv, ev, lv);
    endtask

    task automatic test_backpressure;
        logic [31:0] res;
        logic [4:0]  tg;
        int          lat;
        int          bad;
        run_op(3'd5, 32'd100, 32'd7, 5'd9, res, tg, lat);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || result !== 32'd14 || out_tag !== 5'd9 || in_ready !== 1'b0)
                bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL bp_hold: %0d unstable cycles (last out_valid=%b result=%h tag=%0d in_ready=%b), required 0",
                     bad, out_valid, result, out_tag, in_ready);
        end
        out_ready = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_comb_ready: in_ready=%b before edge, required 0", in_ready);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_flush;
        logic [31:0] res;
        logic [4:0]  tg;
        int          lat;
        int          seen;
        funct3 = 3'd4; op1 = 32'd1000; op2 = 32'd3; in_tag = 5'd4; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        seen = 0;
        for (int i = 1; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_idle: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        tests_run++;
        if (seen != 0) begin
            tests_failed++;
            $display("FAIL flush_no_result: out_valid seen %0d cycles, required 0", seen);
        end
        funct3 = 3'd5; op1 = 32'd50; op2 = 32'd5; in_tag = 5'd2;
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_reject: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
        run_op(3'd0, 32'd3, 32'd4, 5'd17, res, tg, lat);
        tests_run++;
        if (res !== 32'd12 || tg !== 5'd17 || lat !== MUL_LAT) begin
            tests_failed++;
            $display("FAIL flush_next_mul: result=%h tag=%0d lat=%0d, required 0000000c 17 %0d",
                     res, tg, lat, MUL_LAT);
        end
        release_result();
    endtask

    task automatic test_reset_mid;
        logic [31:0] res;
        logic [4:0]  tg;
        int          lat;
        funct3 = 3'd4; op1 = 32'hFFFF_FFF9; op2 = 32'd2; in_tag = 5'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== '0 || out_tag !== '0) begin
            tests_failed++;
            $display("FAIL reset_async: out_valid=%b in_ready=%b result=%h out_tag=%h, required 0 1 0 0",
                     out_valid, in_ready, result, out_tag);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd11, res, tg, lat);
        tests_run++;
        if (res !== 32'hFFFF_FFFF || tg !== 5'd11 || lat !== DIV_LAT) begin
            tests_failed++;
            $display("FAIL reset_recover: result=%h tag=%0d lat=%0d, required ffffffff 11 %0d",
                     res, tg, lat, DIV_LAT);
        end
        release_result();
    endtask

    function automatic logic [31:0] pick_operand;
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom();
        endcase
    endfunction

    task automatic test_random;
        logic [2:0]  f;
        logic [31:0] a, b, res, er;
        logic [4:0]  t, tg;
        int          lat, el;
        for (int i = 0; i < 60; i++) begin
            f  = 3'($urandom_range(0, 7));
            a  = pick_operand();
            b  = pick_operand();
            t  = 5'($urandom_range(0, 31));
            er = ref_result(f, a, b);
            el = ref_latency(f, a, b);
            run_op(f, a, b, t, res, tg, lat);
            tests_run++;
            if (res !== er || tg !== t || lat !== el) begin
                tests_failed++;
                $display("FAIL random[%0d] f=%0d a=%h b=%h: result=%h tag=%0d lat=%0d, required %h %0d %0d",
                         i, f, a, b, res, tg, lat, er, t, el);
            end
            release_result();
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        funct3 = '0; op1 = '0; op2 = '0; in_tag = '0;
        test_reset();
        test_mul();
        test_div();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
